dual_issue_queue: RTL
=====================

# dual_issue_queue

Dual-lane in-order decoded-instruction queue sitting directly downstream of the decode-stage sign extender and register-field decoder. Each cycle it accepts up to two decoded instructions (extended immediate, 5-bit opcode, rd, PC) and presents the two oldest entries to the issue/execute stage. Consumer-controlled pops, all-or-nothing pushes and a single-cycle flush decouple decode from execute stalls and branch redirects.

## Interface
- DEPTH, 8, number of entries; power of two, minimum 4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  discard all entries (branch mispredict / redirect)
- in_valid  input  [1:0]  per-lane push request; lane 0 is older
- in_imm  input  [31:0] x2 (array [1:0])  extended immediate from sign extender
- in_op  input  [4:0] x2  opcode bits [6:2]
- in_rd  input  [4:0] x2  destination register
- in_pc  input  [31:0] x2  instruction PC
- in_ready  output  1  queue can take a two-instruction push this cycle
- out_valid  output  [1:0]  bit0: head entry present; bit1: head+1 present
- out_imm, out_op, out_rd, out_pc  output  same widths x2  head (lane 0) and head+1 (lane 1) payload
- out_pop  input  [1:0]  consumer removes presented entries
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular buffer, DEPTH entries; wr_ptr, rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH; count tracked explicitly (0..DEPTH).
- in_ready = (DEPTH - count) >= 2, from registered count only; no dependency on out_pop in the same cycle.
- Push: effective only when in_ready=1. in_valid=2'b11: lane 0 at wr_ptr, lane 1 at wr_ptr+1, wr_ptr += 2. in_valid=2'b01: lane 0 at wr_ptr, wr_ptr += 1. in_valid=2'b10: lane 1 written at wr_ptr as single entry, wr_ptr += 1. in_valid with in_ready=0: ignored, nothing written; decode must hold.
- Presentation: out_valid[0] = count>=1; out_valid[1] = count>=2. Lane 0 payload from rd_ptr, lane 1 from rd_ptr+1 (wrapped). Payload of an invalid lane driven to all zero.
- Pop: out_pop=2'b01 removes head; 2'b11 removes head and head+1; 2'b10 illegal, treated as 2'b00. Pop bits with corresponding out_valid low are masked (no underflow).
- Simultaneous push and pop: both apply; count_next = count + pushed - popped.
- flush: highest priority; rd_ptr, wr_ptr, count to 0 at the edge; same-cycle push and pop discarded.
- Reset (rst_n low, asynchronous): pointers 0, count 0, out_valid 2'b00, all out payload 0, in_ready 1. Storage array need not be reset.
- No state machine beyond pointer/count state; ordering strictly FIFO, lane 0 always older than lane 1.

## Timing
- Push latency: entry written at edge N appears on out_* in cycle N+1 (no bypass when empty).
- Pop takes effect at the edge; next entries presented in the following cycle.
- in_ready, out_valid, out payload are functions of registered state only; no combinational input-to-output path.
- Full: count=DEPTH-1 or DEPTH gives in_ready=0 even if a pop occurs the same cycle.
- Wrap-around: two-entry push at wr_ptr=DEPTH-1 writes DEPTH-1 and 0; lane-1 read at rd_ptr=DEPTH-1 reads entry 0.
- Reset asserted mid-operation: outputs reach reset values asynchronously, without waiting for clk.

## Test plan
- Reset then push in_valid=2'b11 (imm 0x00000004/0xFFFFF800, op 00100/11000) -> next cycle out_valid=2'b11, lane 0 imm 0x00000004, lane 1 imm 0xFFFFF800, count=2.
- Fill DEPTH=8 with four double pushes, no pops -> count 8, in_ready=0 from count 7 onward; fifth push ignored, contents unchanged.
- Count=7, push 2'b11 with out_pop=2'b11 -> push rejected (in_ready=0), pop applied, count=5.
- Wrap: advance pointers to 7, push two PCs 0x100/0x104 -> entries at 7 and 0, presented in order 0x100 then 0x104.
- Count=3, flush with simultaneous push 2'b11 and pop 2'b01 -> next cycle count=0, out_valid=2'b00, payload zero, in_ready=1.
- Single entry, out_pop=2'b11 -> only head removed, count=0; out_pop=2'b10 with two entries -> no change.

Source files
------------

// File: rtl/dual_issue_queue_if.sv
// Handshake bundle between decode (master side) and the dual-lane issue queue.
// Carries two push lanes, two presented lanes, consumer pops, flush and occupancy.
interface dual_issue_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_imm;
  logic [1:0][4:0]  in_op;
  logic [1:0][4:0]  in_rd;
  logic [1:0][31:0] in_pc;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_imm;
  logic [1:0][4:0]  out_op;
  logic [1:0][4:0]  out_rd;
  logic [1:0][31:0] out_pc;
  logic [1:0]       out_pop;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_imm, in_op, in_rd, in_pc, out_pop,
    input  in_ready, out_valid, out_imm, out_op, out_rd, out_pc, count
  );

  modport slave (
    input  flush, in_valid, in_imm, in_op, in_rd, in_pc, out_pop,
    output in_ready, out_valid, out_imm, out_op, out_rd, out_pc, count
  );
endinterface

// File: rtl/dual_issue_queue.sv
// Dual-lane in-order decoded-instruction queue: up to two pushes and two pops per cycle,
// flush has priority; every output is decoded from registered pointer/count/storage state.
module dual_issue_queue #(
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  dual_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          in_ready_s;
  logic          push_acc_s;
  logic [1:0]    n_push_s;
  logic [1:0]    n_pop_s;
  logic [AW-1:0] rd_nxt_s;
  logic [AW-1:0] wr_nxt_s;
  entry_t        lane0_s;
  entry_t        lane1_s;

  // Admission, pop masking and per-cycle push/pop amounts.
  always_comb begin
    in_ready_s = (CW'(DEPTH) - count_r) >= CW'(2);
    push_acc_s = in_ready_s & ~bus.flush & (|bus.in_valid);
    rd_nxt_s   = rd_ptr_r + AW'(1);
    wr_nxt_s   = wr_ptr_r + AW'(1);
    lane0_s    = '{imm: bus.in_imm[0], op: bus.in_op[0], rd: bus.in_rd[0], pc: bus.in_pc[0]};
    lane1_s    = '{imm: bus.in_imm[1], op: bus.in_op[1], rd: bus.in_rd[1], pc: bus.in_pc[1]};
    if (push_acc_s) begin
      n_push_s = (bus.in_valid == 2'b11) ? 2'd2 : 2'd1;
    end else begin
      n_push_s = 2'd0;
    end
    // 2'b10 is not a legal pop; valid masking prevents underflow.
    case (bus.out_pop)
      2'b01:   n_pop_s = (count_r >= CW'(1)) ? 2'd1 : 2'd0;
      2'b11:   n_pop_s = (count_r >= CW'(2)) ? 2'd2 : ((count_r >= CW'(1)) ? 2'd1 : 2'd0);
      default: n_pop_s = 2'd0;
    endcase
  end

  // Pointer and occupancy state; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (bus.flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(n_push_s);
      rd_ptr_r <= rd_ptr_r + AW'(n_pop_s);
      count_r  <= count_r + CW'(n_push_s) - CW'(n_pop_s);
    end
  end

  // Entry storage; a lone lane-1 push lands at wr_ptr like a single entry.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      case (bus.in_valid)
        2'b11: begin
          mem_r[wr_ptr_r] <= lane0_s;
          mem_r[wr_nxt_s] <= lane1_s;
        end
        2'b01:   mem_r[wr_ptr_r] <= lane0_s;
        2'b10:   mem_r[wr_ptr_r] <= lane1_s;
        default: ;
      endcase
    end
  end

  // Presentation of the two oldest entries; invalid lanes read as zero.
  always_comb begin
    bus.in_ready     = in_ready_s;
    bus.count        = count_r;
    bus.out_valid[0] = count_r >= CW'(1);
    bus.out_valid[1] = count_r >= CW'(2);
    if (bus.out_valid[0]) begin
      bus.out_imm[0] = mem_r[rd_ptr_r].imm;
      bus.out_op[0]  = mem_r[rd_ptr_r].op;
      bus.out_rd[0]  = mem_r[rd_ptr_r].rd;
      bus.out_pc[0]  = mem_r[rd_ptr_r].pc;
    end else begin
      bus.out_imm[0] = 32'd0;
      bus.out_op[0]  = 5'd0;
      bus.out_rd[0]  = 5'd0;
      bus.out_pc[0]  = 32'd0;
    end
    if (bus.out_valid[1]) begin
      bus.out_imm[1] = mem_r[rd_nxt_s].imm;
      bus.out_op[1]  = mem_r[rd_nxt_s].op;
      bus.out_rd[1]  = mem_r[rd_nxt_s].rd;
      bus.out_pc[1]  = mem_r[rd_nxt_s].pc;
    end else begin
      bus.out_imm[1] = 32'd0;
      bus.out_op[1]  = 5'd0;
      bus.out_rd[1]  = 5'd0;
      bus.out_pc[1]  = 32'd0;
    end
  end
endmodule
